// File: rtl/relprime_pkg.sv
// Shared types for the relprime engine: FSM state encoding and the first m to try.
package relprime_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GCD   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int M_START = 2;

endpackage

// File: rtl/relprime_gcd_step.sv
// One subtractive-Euclid step: subtract when a >= b, otherwise swap; flags b == 0.
module relprime_gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_b_zero
);

  always_comb begin
    o_a      = i_a;
    o_b      = i_b;
    o_b_zero = (i_b == '0);
    if (!o_b_zero) begin
      // The a >= b guard means the subtract can never underflow.
      if (i_a >= i_b) begin
        o_a = i_a - i_b;
      end else begin
        o_a = i_b;
        o_b = i_a;
      end
    end
  end

endmodule

// File: rtl/relprime_engine.sv
// Finds the smallest m >= 2 coprime with n using an iterative subtractive GCD.
// Optional RELPRIME_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
//
// state | meaning
// IDLE  | waiting for start; captures n_in
// LOAD  | a <= n, b <= m for the next trial
// GCD   | one subtract or swap per cycle until b == 0
// CHECK | gcd == 1 -> done; else advance m (wrap -> error)
// DONE  | one-cycle done pulse, back to IDLE
module relprime_engine
  import relprime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_err;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_m_inc;
  logic             w_accept;

  relprime_gcd_step #(
    .WIDTH (WIDTH)
  ) u_gcd_step (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_a      (w_a_next),
    .o_b      (w_b_next),
    .o_b_zero (w_b_zero)
  );

  assign w_m_inc  = r_m + WIDTH'(1);
  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_err   <= 1'b0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n <= n_in;
            r_m <= WIDTH'(M_START);
            // gcd(0, m) = m is never 1, so n = 0 has no answer.
            if (n_in == '0) begin
              r_err   <= 1'b1;
              r_out   <= '0;
              r_state <= DONE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          r_a     <= r_n;
          r_b     <= r_m;
          r_state <= GCD;
        end
        GCD: begin
          if (w_b_zero) begin
            r_state <= CHECK;
          end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
          end
        end
        CHECK: begin
          if (r_a == WIDTH'(1)) begin
            r_out   <= r_m;
            r_err   <= 1'b0;
            r_state <= DONE;
          end else if (w_m_inc == '0) begin
            r_m     <= w_m_inc;
            r_out   <= '0;
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_m     <= w_m_inc;
            r_state <= LOAD;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == LOAD) || (r_state == GCD) || (r_state == CHECK);
  assign done = (r_state == DONE);
  assign err  = r_err;
  assign out  = r_out;

`ifdef RELPRIME_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cycle_count <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
    end else if (busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_relprime_engine.sv
// Directed bench for relprime_engine: a 16-bit and an 8-bit instance, hand-computed results.
module tb_relprime_engine;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start16, busy16, done16, err16;
  logic [15:0] n16, out16;
  logic        start8, busy8, done8, err8;
  logic [7:0]  n8, out8;
`ifdef RELPRIME_CYCLE_COUNT_EN
  logic [31:0] cc16, cc8;
  logic [31:0] last_cc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  relprime_engine #(.WIDTH(16)) u_dut16 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start16),
    .n_in  (n16),
    .busy  (busy16),
    .done  (done16),
    .err   (err16),
    .out   (out16)
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    .cycle_count (cc16)
`endif
  );

  relprime_engine #(.WIDTH(8)) u_dut8 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start8),
    .n_in  (n8),
    .busy  (busy8),
    .done  (done8),
    .err   (err8),
    .out   (out8)
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    .cycle_count (cc8)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // exp_busy < 0 skips the exact busy-cycle check.
  task automatic run16(input string tag, input logic [15:0] n, input logic [15:0] exp_out,
                       input logic exp_err, input int exp_busy);
    int cyc;
    int busy_cyc;
    bit seen;
    bit busy_gap;
`ifdef RELPRIME_CYCLE_COUNT_EN
    check_val({tag, "_cc_hold"}, cc16, last_cc);
`endif
    @(negedge CLK);
    start16 = 1'b1;
    n16     = n;
    @(negedge CLK);
    start16 = 1'b0;
    n16     = 16'($urandom);
    cyc = 0; busy_cyc = 0; seen = 0; busy_gap = 0;
    while (!seen && cyc < 60000) begin
      if (done16) begin
        seen = 1;
      end else begin
        if (busy16) busy_cyc++;
        else busy_gap = 1;
        @(negedge CLK);
        cyc++;
      end
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_out"}, 32'(out16), 32'(exp_out));
    check_val({tag, "_err"}, 32'(err16), 32'(exp_err));
    check_val({tag, "_busy_at_done"}, 32'(busy16), 32'd0);
    check_val({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
    if (n == 16'd0) begin
      check_val({tag, "_zero_latency"}, 32'(cyc), 32'd0);
      check_val({tag, "_zero_busy"}, 32'(busy_cyc), 32'd0);
    end
    if (exp_busy >= 0) check_val({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
`ifdef RELPRIME_CYCLE_COUNT_EN
    check_val({tag, "_cc"}, cc16, 32'(busy_cyc));
    last_cc = 32'(busy_cyc);
`endif
    @(negedge CLK);
    check_val({tag, "_done_pulse"}, 32'(done16), 32'd0);
    check_val({tag, "_out_hold"}, 32'(out16), 32'(exp_out));
`ifdef RELPRIME_CYCLE_COUNT_EN
    check_val({tag, "_cc_after"}, cc16, last_cc);
`endif
  endtask

  initial begin
    int dones8;
    logic [7:0] res8;
    logic       rerr8;
    bit         busy8_seen;

    RST_N   = 1'b0;
    start16 = 1'b0; n16 = '0;
    start8  = 1'b0; n8  = '0;
`ifdef RELPRIME_CYCLE_COUNT_EN
    last_cc = '0;
`endif
    repeat (3) @(negedge CLK);
    check_val("rst_busy", 32'(busy16), 32'd0);
    check_val("rst_done", 32'(done16), 32'd0);
    check_val("rst_err",  32'(err16),  32'd0);
    check_val("rst_out",  32'(out16),  32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    run16("n34596", 16'd34596, 16'd5, 1'b0, -1);
    run16("n1",     16'd1,     16'd2, 1'b0, 7);
    run16("n30",    16'd30,    16'd7, 1'b0, -1);
    run16("n0",     16'd0,     16'd0, 1'b1, -1);
    run16("n65535", 16'd65535, 16'd2, 1'b0, -1);

    // 8-bit: start and n_in wiggle during the run and must not disturb it.
    @(negedge CLK);
    start8 = 1'b1;
    n8     = 8'd210;
    dones8 = 0; res8 = '0; rerr8 = 1'b0; busy8_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (i < 10) begin
        start8 = ~start8;
        n8     = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
      if (busy8) busy8_seen = 1;
      if (done8) begin
        dones8++;
        res8  = out8;
        rerr8 = err8;
      end
    end
    check_val("w8_busy_seen", 32'(busy8_seen), 32'd1);
    check_val("w8_done_count", 32'(dones8), 32'd1);
    check_val("w8_out", 32'(res8), 32'd11);
    check_val("w8_err", 32'(rerr8), 32'd0);
    check_val("w8_out_hold", 32'(out8), 32'd11);

    // Reset mid-GCD aborts immediately.
    @(negedge CLK);
    start16 = 1'b1;
    n16     = 16'd34596;
    @(negedge CLK);
    start16 = 1'b0;
    repeat (50) @(negedge CLK);
    check_val("mid_busy_before", 32'(busy16), 32'd1);
    RST_N = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy16), 32'd0);
    check_val("mid_rst_done", 32'(done16), 32'd0);
    check_val("mid_rst_out",  32'(out16),  32'd0);
`ifdef RELPRIME_CYCLE_COUNT_EN
    check_val("mid_rst_cc", cc16, 32'd0);
    last_cc = '0;
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("post_rst_done", 32'(done16), 32'd0);

    run16("n9", 16'd9, 16'd2, 1'b0, -1);
    run16("n4", 16'd4, 16'd3, 1'b0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
